plot_fb_writer: RTL and testbench
=================================

Name: plot_fb_writer

Overview:
Pixel-sink end of the plot interface used by the circle, line and fill generators. Accepts (x, y, colour) plot requests with a valid/ready handshake and buffers them in a small FIFO. Clips off-screen coordinates, linearises to a framebuffer address and issues writes to the framebuffer write port under a grant handshake. Also provides a whole-screen clear sequence.

Parameters:
XRES, 160, horizontal pixels
YRES, 120, vertical pixels
CW, 3, colour bits
AW, 15, framebuffer address width; must satisfy XRES*YRES <= 2^AW
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  plot request valid
in_ready  out  1  sink can accept; combinational = (state==RUN) && !fifo_full
in_x  in  8  pixel x
in_y  in  8  pixel y
in_colour  in  CW  pixel colour
clear_req  in  1  start full-screen clear (single-cycle sample)
clear_colour  in  CW  colour used by clear, sampled with clear_req
busy  out  1  high in DRAIN or CLEAR
mem_we  out  1  write request to framebuffer
mem_addr  out  AW  write address = y*XRES + x
mem_data  out  CW  write colour
mem_gnt  in  1  write accepted this cycle when mem_we&&mem_gnt
clip_cnt  out  16  count of discarded off-screen requests

Behaviour:
- Reset (async, rst=0): state=RUN, FIFO empty, mem_we=0, mem_addr=0, mem_data=0, busy=0, clip_cnt=0. Output stage and FIFO are flushed immediately, including mid-clear and mid-write.
- Handshake: a request transfers on the edge where in_valid&&in_ready. Producer holds in_x/in_y/in_colour stable while in_valid&&!in_ready.
- Output stage: single register driving mem_*. It is "free" when mem_we=0 or mem_we&&mem_gnt. While free and the FIFO is non-empty, it pops the head:
  - in range (x<XRES && y<YRES): load mem_addr=y*XRES+x (AW-bit, no overflow for legal inputs), mem_data=colour, mem_we=1.
  - out of range: discard, set mem_we=0 that cycle, clip_cnt+=1, saturating at 16'hFFFF.
- mem_we and its addr/data hold unchanged until mem_gnt. Sustained mem_gnt=1 gives one write per cycle.
- Latency: a pixel accepted at edge k into an empty FIFO with a free output stage drives mem_we=1 from edge k+1.
- FIFO: no enqueue while full (in_ready=0), so there is no overflow path. Simultaneous push and pop when not full is allowed. Write order equals acceptance order.
- FSM:
  - RUN: clear_req=1 latches clear_colour and moves to DRAIN. A request handshaking in the same cycle is still enqueued.
  - DRAIN: in_ready=0. When the FIFO is empty and the output stage is free, move to CLEAR with counter=0.
  - CLEAR: mem_we=1, mem_addr=counter, mem_data=latched colour. The counter advances only on mem_gnt. After the grant at counter=XRES*YRES-1, mem_we=0 and the FSM returns to RUN.
- clear_req in DRAIN or CLEAR is ignored.
- busy=1 in DRAIN and CLEAR.
- Pixels queued before a clear are written before the clear and therefore erased by it. This ordering is intentional.

Optional Feature:
CLIP_COUNT_EN
- Defined: clip_cnt is a 16-bit saturating counter as specified above.
- Undefined: the counter is not built and clip_cnt is tied to 0. Off-screen requests are still discarded silently, with identical timing.

Test Plan:
- Single pixel (5,3,colour 4), mem_gnt=1: accepted at edge k -> mem_we=1, mem_addr=485, mem_data=4 at edge k+1, then mem_we=0 at edge k+2.
- Burst of 6 pixels (i,i,i) for i=0..5, mem_gnt=0 for 10 cycles then 1: in_ready drops after 4+1 accepted. Writes arrive in order with addresses 0,161,322,483,644,805, and mem_addr is held stable while ungranted.
- Requests (160,0), (0,120), (159,119): exactly one write at addr 19199, clip_cnt=2; clip_cnt=0 with CLIP_COUNT_EN undefined.
- clear_req with clear_colour=2 while 2 pixels are queued, mem_gnt=1: the 2 pixels are written first, then 19200 writes at addr 0..19199 with data 2. busy stays high throughout, in_ready=0, and both return to RUN values afterwards.
- A second clear_req issued mid-clear has no effect: the write count stays at 19200.
- rst asserted at clear counter 500: mem_we=0 and busy=0 immediately, in_ready=1 after release, and the next pixel writes normally with no residual clear writes.

Source files
------------

// File: rtl/plot_fb_writer.sv
// Pixel sink for the plot interface: buffers (x, y, colour) requests, clips and linearises
// them into framebuffer writes, and runs a full-screen clear. Optional macro: CLIP_COUNT_EN.
module plot_fb_writer #(
   parameter int XRES  = 160,
   parameter int YRES  = 120,
   parameter int CW    = 3,
   parameter int AW    = 15,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [7:0]    in_x,
   input  logic [7:0]    in_y,
   input  logic [CW-1:0] in_colour,
   input  logic          clear_req,
   input  logic [CW-1:0] clear_colour,
   output logic          busy,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [CW-1:0] mem_data,
   input  logic          mem_gnt,
   output logic [15:0]   clip_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int EW = 16 + CW;
   localparam logic [AW-1:0] LAST_ADDR = AW'(XRES * YRES - 1);

   typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [EW-1:0] fifo_mem [DEPTH];
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [EW-1:0] head;
   logic [7:0]    head_x;
   logic [7:0]    head_y;
   logic [CW-1:0] head_colour;
   logic [AW-1:0] head_addr;
   logic          head_in_range;
   logic          fifo_empty;
   logic          fifo_full;
   logic          out_free;
   logic          push;
   logic          pop;
   logic          clear_start;
   logic          clear_last;
   logic [CW-1:0] clr_colour;

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign in_ready    = (state == RUN) && !fifo_full;
   assign busy        = (state != RUN);
   assign push        = in_valid && in_ready;
   assign out_free    = !mem_we || mem_gnt;
   // The FIFO is necessarily empty during CLEAR, so the explicit state term only documents intent.
   assign pop         = out_free && !fifo_empty && (state != CLEAR);
   assign clear_start = (state == DRAIN) && fifo_empty && out_free;
   assign clear_last  = (state == CLEAR) && mem_gnt && (mem_addr == LAST_ADDR);

   assign head          = fifo_mem[rd_ptr[PW-1:0]];
   assign head_x        = head[EW-1 -: 8];
   assign head_y        = head[EW-9 -: 8];
   assign head_colour   = head[CW-1:0];
   assign head_in_range = (32'(head_x) < XRES) && (32'(head_y) < YRES);
   assign head_addr     = AW'(head_y) * AW'(XRES) + AW'(head_x);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (clear_req)   state_nxt = DRAIN;
         DRAIN:   if (clear_start) state_nxt = CLEAR;
         CLEAR:   if (clear_last)  state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[PW-1:0]] <= {in_x, in_y, in_colour};
   end

   // During CLEAR, mem_addr doubles as the clear counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         clr_colour <= '0;
      end else begin
         if (state == RUN && clear_req) clr_colour <= clear_colour;
         if (state == CLEAR) begin
            if (mem_gnt) begin
               if (mem_addr == LAST_ADDR) mem_we <= 1'b0;
               else                       mem_addr <= mem_addr + AW'(1);
            end
         end else if (clear_start) begin
            mem_we   <= 1'b1;
            mem_addr <= '0;
            mem_data <= clr_colour;
         end else if (pop) begin
            if (head_in_range) begin
               mem_we   <= 1'b1;
               mem_addr <= head_addr;
               mem_data <= head_colour;
            end else begin
               mem_we <= 1'b0;
            end
         end else if (out_free) begin
            mem_we <= 1'b0;
         end
      end
   end

`ifdef CLIP_COUNT_EN
   logic [15:0] clip_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clip_q <= '0;
      end else if (pop && !head_in_range && clip_q != 16'hFFFF) begin
         clip_q <= clip_q + 16'd1;
      end
   end

   assign clip_cnt = clip_q;
`else
   assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_plot_fb_writer.sv
// Directed self-checking bench for plot_fb_writer: single write, burst backpressure,
// clipping, clear ordering with an ignored second clear, and reset mid-clear.
module tb_plot_fb_writer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_x;
   logic [7:0]  in_y;
   logic [2:0]  in_colour;
   logic        clear_req;
   logic [2:0]  clear_colour;
   logic        busy;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [2:0]  mem_data;
   logic        mem_gnt;
   logic [15:0] clip_cnt;

   int testsRun = 0;
   int testsFailed = 0;

   logic [17:0] wrQ[$];
   logic        pendHold = 1'b0;
   logic [14:0] holdAddr = '0;

   plot_fb_writer dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
      .clear_req(clear_req), .clear_colour(clear_colour),
      .busy(busy),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_gnt(mem_gnt),
      .clip_cnt(clip_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Presents one pixel and returns just after the edge on which it was accepted.
   task automatic applyStimulus(input int x, input int y, input int c);
      int cnt;
      in_valid  = 1'b1;
      in_x      = 8'(x);
      in_y      = 8'(y);
      in_colour = 3'(c);
      cnt = 0;
      while (!in_ready && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      checkOutput("send_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Write monitor sampled mid-cycle; also checks that an ungranted write is held.
   always @(negedge clk) begin
      if (!rst) begin
         pendHold = 1'b0;
      end else begin
         if (pendHold) begin
            checkOutput("hold_we", 32'(mem_we), 1);
            checkOutput("hold_addr", 32'(mem_addr), 32'(holdAddr));
         end
         if (mem_we && mem_gnt) wrQ.push_back({mem_addr, mem_data});
         pendHold = mem_we && !mem_gnt;
         holdAddr = mem_addr;
      end
   end

   initial begin
      int cyc;
      int bad;
      int rdyBad;
      logic [17:0] entry;
      logic [31:0] expClip;

      rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
      clear_req = 1'b0; clear_colour = '0; mem_gnt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_we", 32'(mem_we), 0);
      checkOutput("rst_addr", 32'(mem_addr), 0);
      checkOutput("rst_data", 32'(mem_data), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_clip", 32'(clip_cnt), 0);
      checkOutput("rst_ready", 32'(in_ready), 1);
      rst = 1'b1;
      @(posedge clk); #1;

      // Single pixel (5,3,4): write 3*160+5 = 485 one edge after acceptance
      mem_gnt = 1'b1;
      applyStimulus(5, 3, 4);
      checkOutput("px_we_k", 32'(mem_we), 0);
      @(posedge clk); #1;
      checkOutput("px_we_k1", 32'(mem_we), 1);
      checkOutput("px_addr", 32'(mem_addr), 485);
      checkOutput("px_data", 32'(mem_data), 4);
      @(posedge clk); #1;
      checkOutput("px_we_k2", 32'(mem_we), 0);
      checkOutput("px_count", 32'(wrQ.size()), 1);
      wrQ.delete();

      // Burst of 6 with grant withheld: 1 in output stage + 4 in FIFO, then stall
      mem_gnt = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) applyStimulus(i, i, i);
            checkOutput("burst_full_rdy", 32'(in_ready), 0);
            applyStimulus(5, 5, 5);
         end
         begin
            repeat (10) @(posedge clk);
            #1;
            mem_gnt = 1'b1;
         end
      join
      repeat (10) @(posedge clk);
      #1;
      checkOutput("burst_count", 32'(wrQ.size()), 6);
      for (int i = 0; i < 6; i++) begin
         entry = (i < wrQ.size()) ? wrQ[i] : '1;
         checkOutput($sformatf("burst_w%0d", i), 32'(entry), 32'({15'(i * 161), 3'(i)}));
      end
      wrQ.delete();

      // Clipping: two off-screen, one at the last legal pixel
      applyStimulus(160, 0, 1);
      applyStimulus(0, 120, 1);
      applyStimulus(159, 119, 7);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("clip_count_w", 32'(wrQ.size()), 1);
      entry = (wrQ.size() > 0) ? wrQ[0] : '1;
      checkOutput("clip_w0", 32'(entry), 32'({15'd19199, 3'd7}));
`ifdef CLIP_COUNT_EN
      expClip = 2;
`else
      expClip = 0;
`endif
      checkOutput("clip_cnt", 32'(clip_cnt), expClip);
      wrQ.delete();

      // Clear with two pixels pending; a second clear mid-way must be ignored
      mem_gnt = 1'b0;
      applyStimulus(10, 1, 5);
      applyStimulus(20, 2, 6);
      clear_req = 1'b1;
      clear_colour = 3'd2;
      @(posedge clk); #1;
      clear_req = 1'b0;
      clear_colour = 3'd5;
      checkOutput("clr_busy", 32'(busy), 1);
      checkOutput("clr_ready", 32'(in_ready), 0);
      mem_gnt = 1'b1;
      cyc = 0;
      rdyBad = 0;
      while (busy && cyc < 25000) begin
         if (in_ready) rdyBad++;
         @(posedge clk); #1;
         cyc++;
         clear_req = (cyc == 100);
      end
      clear_req = 1'b0;
      checkOutput("clr_done", 32'(busy), 0);
      checkOutput("clr_ready_low", 32'(rdyBad), 0);
      checkOutput("clr_count", 32'(wrQ.size()), 19202);
      entry = (wrQ.size() > 0) ? wrQ[0] : '1;
      checkOutput("clr_pre0", 32'(entry), 32'({15'd170, 3'd5}));
      entry = (wrQ.size() > 1) ? wrQ[1] : '1;
      checkOutput("clr_pre1", 32'(entry), 32'({15'd340, 3'd6}));
      bad = 0;
      for (int i = 2; i < wrQ.size(); i++) begin
         if (wrQ[i] !== {15'(i - 2), 3'd2}) bad++;
      end
      checkOutput("clr_errs", 32'(bad), 0);
      checkOutput("clr_end_ready", 32'(in_ready), 1);
      checkOutput("clr_end_we", 32'(mem_we), 0);
      wrQ.delete();

      // Reset asserted at clear counter 500
      clear_req = 1'b1;
      clear_colour = 3'd6;
      @(posedge clk); #1;
      clear_req = 1'b0;
      cyc = 0;
      while (!(busy && mem_addr == 15'd500) && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("rc_reach", 32'(mem_addr), 500);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rc_we", 32'(mem_we), 0);
      checkOutput("rc_busy", 32'(busy), 0);
      checkOutput("rc_addr", 32'(mem_addr), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      checkOutput("rc_ready", 32'(in_ready), 1);
      wrQ.delete();
      applyStimulus(1, 1, 3);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("rc_count", 32'(wrQ.size()), 1);
      entry = (wrQ.size() > 0) ? wrQ[0] : '1;
      checkOutput("rc_w0", 32'(entry), 32'({15'd161, 3'd3}));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
